// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the mandelbrot block dispatcher.
//   state_e     : dispatcher FSM states (idle / issuing / draining results)
//   core_idx_w  : width of a round-robin core pointer for a given core count
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // clog2(n), but never narrower than one bit so a single-core build still has a pointer.
    function automatic int unsigned core_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_scanner.sv
// Raster-order pixel walker for one block job.
//   CLK, RST         : clock, synchronous active-high reset
//   load             : latch start point, step and block size; restart at pixel (0,0)
//   next             : advance to the next pixel in raster order
//   start_real/imag  : c of pixel (0,0)
//   step             : per-pixel increment on both axes
//   block_w/block_h  : block width/height minus 1
//   c_real/c_imag    : c of the current pixel
//   last_pixel       : current pixel is the final one of the block
module pixel_scanner #(
    parameter int unsigned N     = 16,
    parameter int unsigned DIM_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             next,
    input  logic [N-1:0]     start_real,
    input  logic [N-1:0]     start_imag,
    input  logic [N-1:0]     step,
    input  logic [DIM_W-1:0] block_w,
    input  logic [DIM_W-1:0] block_h,
    output logic [N-1:0]     c_real,
    output logic [N-1:0]     c_imag,
    output logic             last_pixel
);

    logic [DIM_W-1:0] x_q, y_q, w_q, h_q;
    logic [N-1:0]     row_real_q, step_q, c_real_q, c_imag_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_real_q <= '0;
            step_q     <= '0;
            c_real_q   <= '0;
            c_imag_q   <= '0;
        end else if (load) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= block_w;
            h_q        <= block_h;
            row_real_q <= start_real;
            step_q     <= step;
            c_real_q   <= start_real;
            c_imag_q   <= start_imag;
        end else if (next) begin
            if (x_q == w_q) begin
                // Row wrap: real part restarts at the latched origin, imag steps once.
                x_q      <= '0;
                y_q      <= y_q + DIM_W'(1);
                c_real_q <= row_real_q;
                c_imag_q <= c_imag_q + step_q;
            end else begin
                x_q      <= x_q + DIM_W'(1);
                c_real_q <= c_real_q + step_q;
            end
        end
    end

    assign c_real     = c_real_q;
    assign c_imag     = c_imag_q;
    assign last_pixel = (x_q == w_q) && (y_q == h_q);

endmodule

// File: rtl/mandelbrot_dispatcher.sv
// Block job dispatcher: scans one block in raster order, hands pixels round-robin to
// NUM_CORES mandelbrot cores and streams the iteration counts back in raster order.
//   CLK, RST                   : clock, synchronous active-high reset
//   cfg_*                      : job request (valid/ready) with start point, step, size-1
//   abort                      : drop the current job, return to idle
//   core_run                   : one-cycle start pulse per core
//   core_c_real/core_c_imag    : per-core c, slice [i*N +: N], held until result consumed
//   core_done/core_count       : per-core done level and result, slice [i*NC +: NC]
//   out_valid/out_ready        : result stream handshake
//   out_data/out_last          : iteration count, final-pixel marker
//   busy                       : job in progress
module mandelbrot_dispatcher
    import mandelbrot_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned NC        = 8,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DIM_W     = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [N-1:0]            cfg_c_real,
    input  logic [N-1:0]            cfg_c_imag,
    input  logic [N-1:0]            cfg_c_step,
    input  logic [DIM_W-1:0]        cfg_block_w,
    input  logic [DIM_W-1:0]        cfg_block_h,
    input  logic                    abort,
    output logic [NUM_CORES-1:0]    core_run,
    output logic [NUM_CORES*N-1:0]  core_c_real,
    output logic [NUM_CORES*N-1:0]  core_c_imag,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES*NC-1:0] core_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NC-1:0]           out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned CORE_IDX_W = core_idx_w(NUM_CORES);
    localparam int unsigned CNT_W      = 2 * DIM_W + 1;
    localparam logic [CORE_IDX_W-1:0] PTR_MAX = CORE_IDX_W'(NUM_CORES - 1);

    function automatic logic [CORE_IDX_W-1:0] ptr_inc(input logic [CORE_IDX_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + CORE_IDX_W'(1);
    endfunction

    state_e                  state_q;
    logic                    busy_q, cfg_ready_q;
    logic [CORE_IDX_W-1:0]   issue_ptr_q, emit_ptr_q;
    logic [NUM_CORES-1:0]    issued_q;
    logic [NUM_CORES-1:0]    run_q;      // start pulse, also first guard cycle
    logic [NUM_CORES-1:0]    run_d1_q;   // second guard cycle
    logic [N-1:0]            c_real_q [NUM_CORES];
    logic [N-1:0]            c_imag_q [NUM_CORES];
    logic [CNT_W-1:0]        emit_cnt_q, last_idx_q;

    logic                    cfg_fire, issue_fire, out_fire;
    logic [NUM_CORES-1:0]    guard_ok;
    logic [N-1:0]            scan_c_real, scan_c_imag;
    logic                    scan_last;
    logic [DIM_W:0]          w_plus1, h_plus1;
    logic [CNT_W-1:0]        job_last_idx;
    logic [NC-1:0]           count_arr [NUM_CORES];

    pixel_scanner #(
        .N     (N),
        .DIM_W (DIM_W)
    ) u_scanner (
        .CLK        (CLK),
        .RST        (RST),
        .load       (cfg_fire),
        .next       (issue_fire),
        .start_real (cfg_c_real),
        .start_imag (cfg_c_imag),
        .step       (cfg_c_step),
        .block_w    (cfg_block_w),
        .block_h    (cfg_block_h),
        .c_real     (scan_c_real),
        .c_imag     (scan_c_imag),
        .last_pixel (scan_last)
    );

    // Index of the final pixel: (w+1)*(h+1)-1, fits CNT_W bits even for the largest block.
    assign w_plus1      = {1'b0, cfg_block_w} + (DIM_W + 1)'(1);
    assign h_plus1      = {1'b0, cfg_block_h} + (DIM_W + 1)'(1);
    assign job_last_idx = CNT_W'(w_plus1) * CNT_W'(h_plus1) - CNT_W'(1);

    assign cfg_fire   = cfg_valid & cfg_ready_q;
    assign issue_fire = (state_q == StRun) & ~abort & ~issued_q[issue_ptr_q];
    // done is untrustworthy until two cycles after the run pulse.
    assign guard_ok   = ~run_q & ~run_d1_q;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            count_arr[i] = core_count[i*NC +: NC];
        end
    end

    assign out_valid = busy_q & issued_q[emit_ptr_q] & core_done[emit_ptr_q]
                       & guard_ok[emit_ptr_q];
    assign out_data  = count_arr[emit_ptr_q];
    assign out_last  = out_valid & (emit_cnt_q == last_idx_q);
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            issue_ptr_q <= '0;
            emit_ptr_q  <= '0;
            issued_q    <= '0;
            run_q       <= '0;
            run_d1_q    <= '0;
            emit_cnt_q  <= '0;
            last_idx_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                c_real_q[i] <= '0;
                c_imag_q[i] <= '0;
            end
        end else begin
            run_q    <= '0;
            run_d1_q <= run_q;
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                        issue_ptr_q <= '0;
                        emit_ptr_q  <= '0;
                        emit_cnt_q  <= '0;
                        last_idx_q  <= job_last_idx;
                    end
                end
                StRun, StDrain: begin
                    if (abort) begin
                        // Cores keep running; clearing issued makes their results ignored.
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        issued_q    <= '0;
                    end else begin
                        // Issue needs !issued and emit needs issued, so they never hit
                        // the same core in one cycle.
                        if (issue_fire) begin
                            issued_q[issue_ptr_q] <= 1'b1;
                            run_q[issue_ptr_q]    <= 1'b1;
                            c_real_q[issue_ptr_q] <= scan_c_real;
                            c_imag_q[issue_ptr_q] <= scan_c_imag;
                            issue_ptr_q           <= ptr_inc(issue_ptr_q);
                            if (scan_last) begin
                                state_q <= StDrain;
                            end
                        end
                        if (out_fire) begin
                            issued_q[emit_ptr_q] <= 1'b0;
                            emit_ptr_q           <= ptr_inc(emit_ptr_q);
                            emit_cnt_q           <= emit_cnt_q + CNT_W'(1);
                            if (out_last) begin
                                state_q     <= StIdle;
                                busy_q      <= 1'b0;
                                cfg_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        core_c_real = '0;
        core_c_imag = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_c_real[i*N +: N] = c_real_q[i];
            core_c_imag[i*N +: N] = c_imag_q[i];
        end
    end

    assign core_run  = run_q;
    assign busy      = busy_q;
    assign cfg_ready = cfg_ready_q;

endmodule
